sync_fifo_stat: RTL and testbench

- Parametrised synchronous FIFO; successor to the fixed 32x8 FIFO. Width and depth are configurable, and depth need not be a power of two.
- Adds:
  - occupancy count
  - programmable almost-full / almost-empty flags
  - simultaneous read/write at full
  - registered read data with a valid strobe
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between producer/consumer blocks in the same clock domain.

---
 rtl/sync_fifo_stat.sv | 165 ++++++++++++++++
 tb/tb_sync_fifo_stat.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_stat.sv
// Parametrised synchronous FIFO with occupancy count, programmable watermarks,
// registered read data, flush and sticky error flags. Define SYNC_FIFO_ASSERT_EN for inline assertions.
module sync_fifo_stat #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
    localparam logic          AF_RST   = (AF_LEVEL == 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [CW-1:0]    w_count_nxt;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign w_rd_acc  = rd_en & ~r_empty;
    assign w_wr_acc  = wr_en & (~r_full | w_rd_acc);
    assign w_ovf_evt = wr_en & ~w_wr_acc;
    assign w_udf_evt = rd_en & r_empty;

    // Next occupancy from the accepted read/write pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; reset and flush suppress the write.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, count, read port, flags and sticky errors.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr       <= {PW{1'b0}};
            r_rd_ptr       <= {PW{1'b0}};
            r_count        <= {CW{1'b0}};
            r_rd_data      <= {WIDTH{1'b0}};
            r_rd_valid     <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= AF_RST;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (flush) begin
            // rd_data and error flags deliberately keep their values
            r_wr_ptr       <= {PW{1'b0}};
            r_rd_ptr       <= {PW{1'b0}};
            r_count        <= {CW{1'b0}};
            r_rd_valid     <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= AF_RST;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= ptr_inc(r_rd_ptr);
                r_rd_data <= r_mem[r_rd_ptr];
            end else begin
                r_rd_ptr  <= r_rd_ptr;
                r_rd_data <= r_rd_data;
            end
            r_rd_valid     <= w_rd_acc;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CNT_FULL);
            r_empty        <= (w_count_nxt == {CW{1'b0}});
            r_almost_full  <= (w_count_nxt >= AF_CNT);
            r_almost_empty <= (w_count_nxt <= AE_CNT);
            // A new error event wins over a coincident clear.
            r_overflow     <= w_ovf_evt | (r_overflow & ~clear_err);
            r_underflow    <= w_udf_evt | (r_underflow & ~clear_err);
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

`ifdef SYNC_FIFO_ASSERT_EN
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_param_chk
        $error("sync_fifo_stat: require AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    a_count_max: assert property (@(posedge clk) disable iff (!reset_n)
        count <= CNT_FULL);
    a_empty_dec: assert property (@(posedge clk) disable iff (!reset_n)
        empty == (count == {CW{1'b0}}));
    a_full_dec: assert property (@(posedge clk) disable iff (!reset_n)
        full == (count == CNT_FULL));
    a_rd_known: assert property (@(posedge clk) disable iff (!reset_n)
        rd_valid |-> !$isunknown(rd_data));
    // Flush is the only legal way to move count by more than one.
    a_count_step: assert property (@(posedge clk) disable iff (!reset_n)
        ($past(reset_n) && !$past(flush)) |->
        ((count == $past(count)) || (count == $past(count) + CW'(1)) ||
         (count + CW'(1) == $past(count))));
    a_ovf_sticky: assert property (@(posedge clk) disable iff (!reset_n)
        $fell(overflow) |-> ($past(clear_err) || !$past(reset_n)));
    a_udf_sticky: assert property (@(posedge clk) disable iff (!reset_n)
        $fell(underflow) |-> ($past(clear_err) || !$past(reset_n)));
`else
`endif

endmodule

// File: tb/tb_sync_fifo_stat.sv
// Directed self-checking bench for sync_fifo_stat (WIDTH=32, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo_stat;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clear_err;

    int n_tests;
    int n_fail;

    sync_fifo_stat #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        clear_err = 1'b1; tick(); clear_err = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b exp 0", almost_full); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b%b exp 00", overflow, underflow); end
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            push(32'(i));
            n_tests++; if (count !== i[3:0]) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
            n_tests++; if (almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b", i, almost_empty); end
            n_tests++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got %b", i, almost_full); end
            n_tests++; if (full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b", i, full); end
        end
        push(32'h9);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b exp 1", overflow); end
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_ovf_count got %0d exp 8", count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            pop();
            n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got %b exp 1", i, rd_valid); end
            n_tests++; if (rd_data !== 32'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, rd_data, i); end
            n_tests++; if (count !== 4'(8 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 8 - i); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty); end
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_pulse got %b exp 0", rd_valid); end
        pop();
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got %b exp 1", underflow); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_udf_valid got %b exp 0", rd_valid); end
        n_tests++; if (rd_data !== 32'h8) begin n_fail++; $display("FAIL drain_hold got %h exp 8", rd_data); end
        clear_errors();
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL drain_clear got %b%b exp 00", overflow, underflow); end
    endtask

    task automatic test_empty_rw();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h77; tick(); wr_en = 1'b0; rd_en = 1'b0;
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL erw_count got %0d exp 1", count); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL erw_valid got %b exp 0", rd_valid); end
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL erw_underflow got %b exp 1", underflow); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL erw_overflow got %b exp 0", overflow); end
        pop();
        n_tests++; if (rd_data !== 32'h77) begin n_fail++; $display("FAIL erw_data got %h exp 77", rd_data); end
        clear_errors();
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 8; i++) push(32'h21 + 32'(i));
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hA; tick(); wr_en = 1'b0; rd_en = 1'b0;
        n_tests++; if (rd_data !== 32'h21) begin n_fail++; $display("FAIL sim_data got %h exp 21", rd_data); end
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL sim_count got %0d exp 8", count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sim_overflow got %b exp 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            pop();
            if (i < 7) begin
                n_tests++; if (rd_data !== 32'h22 + 32'(i)) begin n_fail++; $display("FAIL sim_drain[%0d] got %h exp %h", i, rd_data, 32'h22 + 32'(i)); end
            end else begin
                n_tests++; if (rd_data !== 32'hA) begin n_fail++; $display("FAIL sim_last got %h exp a", rd_data); end
            end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_empty got %b exp 1", empty); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) push(32'h10 + 32'(r * 5 + k));
            for (int k = 0; k < 5; k++) begin
                pop();
                n_tests++; if (rd_data !== 32'h10 + 32'(r * 5 + k)) begin n_fail++; $display("FAIL wrap_data[%0d][%0d] got %h exp %h", r, k, rd_data, 32'h10 + 32'(r * 5 + k)); end
            end
            n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp 0", r, count); end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) push(32'h31 + 32'(i));
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h99; tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", empty); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", rd_valid); end
        n_tests++; if (rd_data !== 32'h1E) begin n_fail++; $display("FAIL flush_hold got %h exp 1e", rd_data); end
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL flush_err got %b%b exp 00", overflow, underflow); end
        push(32'h55);
        pop();
        n_tests++; if (rd_data !== 32'h55) begin n_fail++; $display("FAIL flush_after got %h exp 55", rd_data); end
        n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after_valid got %b exp 1", rd_valid); end
    endtask

    task automatic test_clear_err();
        for (int i = 0; i < 9; i++) push(32'h40 + 32'(i));
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set got %b exp 1", overflow); end
        clear_errors();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_clear got %b exp 0", overflow); end
        clear_err = 1'b1; wr_en = 1'b1; wr_data = 32'h66; tick(); clear_err = 1'b0; wr_en = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins got %b exp 1", overflow); end
        rd_en = 1'b1; wr_en = 1'b1; reset_n = 1'b0; tick(); rd_en = 1'b0; wr_en = 1'b0;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL mrst_count got %0d exp 0", count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mrst_overflow got %b exp 0", overflow); end
        n_tests++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin n_fail++; $display("FAIL mrst_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
        n_tests++; if ({rd_valid, rd_data} !== 33'h0) begin n_fail++; $display("FAIL mrst_rd got %b/%h exp 0/0", rd_valid, rd_data); end
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        clk = 1'b0; reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 32'h0;
        rd_en = 1'b0; clear_err = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_empty_rw();
        test_simul_full();
        test_wrap();
        test_flush();
        test_clear_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
